// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX queue on the CPU data bus.
// Define DBUS_UART_TX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module dbus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] drdata,
  output logic        hit,
  output logic        txd,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] INFO_VAL  = 16'(CLKS_PER_BIT);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter;
  logic        overflow;
  logic [2:0]  count;
  logic [7:0]  head;

  logic sel_tx, sel_status, sel_info;
  logic baud_last, full, empty, busy;
  logic pop, wr_req, push, ovf_set, ovf_clr;

  assign sel_tx     = daddr[31:2] == BASE_ADDR[31:2];
  assign sel_status = daddr[31:2] == BASE_ADDR[31:2] + 30'd1;
  assign sel_info   = daddr[31:2] == BASE_ADDR[31:2] + 30'd2;
  assign hit        = sel_tx | sel_status | sel_info;

  assign baud_last = baud_cnt == BAUD_LAST;
  assign busy      = state != IDLE;
  assign empty     = count == 3'd0;

  // A pop happens when IDLE sees data, or at the last STOP cycle for back-to-back frames.
  assign pop     = !empty && ((state == IDLE) || (state == STOP && baud_last));
  assign wr_req  = sel_tx && we[0];
  assign push    = wr_req && (!full || pop);
  assign ovf_set = wr_req && full && !pop;
  assign ovf_clr = sel_status && we[0] && dwdata[3];

`ifdef DBUS_UART_TX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;

  assign full = count == 3'd4;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dwdata[7:0];
  end
`else
  logic [7:0] hold;

  assign full = count == 3'd1;
  assign head = hold;

  always_ff @(posedge clk) begin
    if (push) hold <= dwdata[7:0];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 3'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // A set on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  always_comb begin
    drdata = 32'd0;
    if (sel_status)    drdata = {25'd0, count, overflow, empty, full, busy};
    else if (sel_info) drdata = {16'd0, INFO_VAL};
  end

  // txd is registered and always loaded with the level of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shifter  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shifter  <= head;
            baud_cnt <= 16'd0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            txd      <= shifter[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= 16'd0;
            shifter  <= {1'b0, shifter[7:1]};
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= 16'd0;
            if (pop) begin
              shifter <= head;
              txd     <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Bench for dbus_uart_tx: directed register/frame scenarios plus random bus traffic,
// checked every cycle against a frame-level reference model of the serial line.
module tb_dbus_uart_tx;
  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
`ifdef DBUS_UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dwdata = 32'd0;
  logic [3:0]  we = 4'd0;
  logic [31:0] drdata;
  logic        hit;
  logic        txd;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbus_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .we(we),
    .drdata(drdata), .hit(hit), .txd(txd), .fsm_state(fsm_state)
  );

  // Reference model: byte queue, position within the current frame (-1 = line idle), sticky flag.
  logic [7:0] exp_q[$];
  int         frame_pos = -1;
  logic [7:0] cur_byte = 8'd0;
  logic       m_ovf = 1'b0;

  function automatic void model_reset();
    exp_q.delete();
    frame_pos = -1;
    m_ovf = 1'b0;
  endfunction

  function automatic logic model_txd();
    int slot;
    if (frame_pos < 0) return 1'b1;
    slot = frame_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur_byte[slot-1];
  endfunction

  function automatic logic [31:0] model_status();
    logic [2:0] n;
    n = 3'(exp_q.size());
    return {25'd0, n, m_ovf, exp_q.size() == 0, exp_q.size() == DEPTH, frame_pos >= 0};
  endfunction

  function automatic void model_edge();
    bit popped;
    bit full_pre;
    full_pre = exp_q.size() == DEPTH;
    popped = 1'b0;
    if (frame_pos < 0 || frame_pos == FRAME - 1) begin
      if (exp_q.size() > 0) begin
        cur_byte = exp_q.pop_front();
        frame_pos = 0;
        popped = 1'b1;
      end else begin
        frame_pos = -1;
      end
    end else begin
      frame_pos++;
    end
    if (daddr[31:2] == BASE[31:2] && we[0]) begin
      if (!full_pre || popped) exp_q.push_back(dwdata[7:0]);
      else m_ovf = 1'b1;
    end else if (daddr[31:2] == BASE[31:2] + 30'd1 && we[0] && dwdata[3]) begin
      m_ovf = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check("txd", {31'd0, txd}, {31'd0, model_txd()});
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
    daddr = addr;
    dwdata = data;
    we = wen;
    tick();
    we = 4'd0;
    daddr = BASE + 32'd8;
  endtask

  task automatic read_status(input string tag);
    we = 4'd0;
    daddr = BASE + 32'd4;
    #1;
    check(tag, drdata, model_status());
    check({tag, "_hit"}, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    int r;
    model_reset();
    #23;
    check("rst_txd", {31'd0, txd}, 32'd1);
    read_status("rst_status");
    check("rst_status_val", drdata, 32'h0000_0004);
    @(posedge clk);
    #2 reset = 1'b1;

    // Register decode and read-only values.
    daddr = 32'hFFFF_FF08; #1;
    check("info", drdata, 32'h0000_0004);
    check("info_hit", {31'd0, hit}, 32'd1);
    daddr = 32'hFFFF_FF0C; #1;
    check("beyond_hit", {31'd0, hit}, 32'd0);
    check("beyond_data", drdata, 32'd0);
    daddr = 32'hFFFF_FEFC; #1;
    check("below_hit", {31'd0, hit}, 32'd0);
    daddr = 32'hFFFF_FF00; #1;
    check("txdata_hit", {31'd0, hit}, 32'd1);
    daddr = 32'hFFFF_FF07; #1;
    check("status_byteaddr", drdata, 32'h0000_0004);

    // Single 0x55 frame.
    bus_write(BASE, 32'h0000_0055, 4'b0001);
    idle(FRAME + 5);
    read_status("after_55");
    check("after_55_val", drdata, 32'h0000_0004);

    // Upper byte lanes alone never enqueue.
    bus_write(BASE, 32'hFFFF_FF99, 4'b1110);
    idle(5);
    read_status("no_enq");

    // Back-to-back burst, then one write too many.
    for (int i = 1; i <= 5; i++) bus_write(BASE, i, 4'b0001);
    read_status("burst_full");
    bus_write(BASE, 32'h0000_0006, 4'b0001);
    read_status("burst_ovf");
    check("ovf_bit", {31'd0, drdata[3]}, 32'd1);
    bus_write(BASE + 32'd4, 32'h0000_0008, 4'b0001);
    read_status("ovf_clr");
    check("ovf_bit_clr", {31'd0, drdata[3]}, 32'd0);
    idle(6 * FRAME);
    read_status("burst_drained");

    // Reset in the middle of a frame with data still queued.
    bus_write(BASE, 32'h0000_00A5, 4'b0001);
    bus_write(BASE, 32'h0000_0011, 4'b0001);
    bus_write(BASE, 32'h0000_0022, 4'b0001);
    idle(10);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("abort_txd", {31'd0, txd}, 32'd1);
    idle(3);
    #2 reset = 1'b1;
    read_status("abort_status");
    check("abort_status_val", drdata, 32'h0000_0004);
    idle(2 * FRAME);

    // Random bus traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        bus_write(BASE, $urandom, 4'($urandom_range(0, 15)));
      end else if (r == 3) begin
        bus_write(BASE + 32'd4, $urandom, 4'($urandom_range(0, 15)));
      end else if (r == 4) begin
        bus_write(BASE + 32'd8, $urandom, 4'($urandom_range(0, 15)));
      end else if (r == 5) begin
        read_status("rand_status");
        tick();
      end else begin
        tick();
      end
    end
    idle(6 * FRAME);
    read_status("final_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_uart_tx.md
DBUS_UART_TX -- requirements
Module: dbus_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_FF00, word-aligned base of the 3-word register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434; clk cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port daddr  input  32  CPU data-bus byte address.
REQ-006 SHALL have port dwdata  input  32  CPU data-bus write data.
REQ-007 SHALL have port we  input  4  CPU byte-lane write enables; we[0] qualifies byte 0.
REQ-008 SHALL have port drdata  output  32  read data for a register hit; 0 otherwise.
REQ-009 SHALL have port hit  output  1  high when daddr[31:2] matches one of the three register words; used by the bus mux.
REQ-010 SHALL have port txd  output  1  serial line, idle high, 8N1, LSB first.

Function
REQ-011 SHALL decode registers: BASE+0 TXDATA (write only), BASE+4 STATUS (read; write-1-to-clear), BASE+8 INFO (read only, constant CLKS_PER_BIT in [15:0]).
REQ-012 SHALL make drdata and hit combinational from daddr, with no read side effects.
REQ-013 SHALL return STATUS as: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[6:4] queue count, other bits 0.
REQ-014 SHALL enqueue dwdata[7:0] at the rising edge where daddr hits TXDATA and we[0]=1; we[3:1] ignored.
REQ-015 SHALL drop a TXDATA write when the queue is full and no pop occurs on the same edge, and SHALL set overflow.
REQ-016 SHALL accept a write to a full queue when a pop occurs on the same edge; count unchanged, overflow not set.
REQ-017 SHALL clear overflow on a write to STATUS with we[0]=1 and dwdata[3]=1; a set in the same cycle wins over the clear.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: txd=1; if the queue is non-empty, at the next edge pop the head into an 8-bit shifter, clear the baud counter and enter START.
REQ-020 START: txd=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-021 DATA: txd=shifter[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit index 7 enter STOP.
REQ-022 STOP: txd=1 for CLKS_PER_BIT cycles; on its last cycle, pop and go to START if the queue is non-empty, otherwise go to IDLE (no idle gap between back-to-back frames).
REQ-023 SHALL make a frame exactly 10*CLKS_PER_BIT cycles; txd falls exactly 1 edge after the enqueuing edge when IDLE with an empty queue.
REQ-024 SHALL drive txd from a flop (glitch-free).
REQ-025 SHALL wrap queue read/write pointers modulo depth; count SHALL saturate at neither end (full and empty guard).

Reset
REQ-026 reset low SHALL immediately force txd=1, FSM=IDLE, queue empty (count 0, pointers 0), overflow=0, baud and bit counters 0.
REQ-027 reset asserted mid-frame SHALL abort the frame; txd returns high with no further bits, and the queued data is discarded.
REQ-028 After reset release, STATUS SHALL read 32'h0000_0004.

Configuration
REQ-029 With macro DBUS_UART_TX_FIFO_EN defined, the queue SHALL be a 4-entry FIFO (count 0..4).
REQ-030 Without DBUS_UART_TX_FIFO_EN, the queue SHALL be a single holding register (count 0..1, full when 1); all other behaviour is unchanged.

Verification (CLKS_PER_BIT=4, BASE_ADDR default, FIFO enabled unless stated)
REQ-031 Write 0x55 to 0xFFFFFF00 with we=4'b0001 -> txd low 1 edge later, then bits 1,0,1,0,1,0,1,0 then stop, each 4 cycles; 40-cycle frame; STATUS returns 0x04 after the frame.
REQ-032 Write 0x01,0x02,0x03,0x04,0x05 back-to-back while IDLE -> first write popped immediately, remaining four fill the FIFO, all five frames sent with no gap, overflow=0; sixth immediate write -> dropped, STATUS bit3=1; writing 0x8 to 0xFFFFFF04 -> bit3=0.
REQ-033 Write with we=4'b1110 to TXDATA -> no enqueue, txd stays 1; reading 0xFFFFFF08 -> 0x00000004; reading 0xFFFFFF0C -> hit=0, drdata=0.
REQ-034 Assert reset 13 cycles into a 0xA5 frame with 2 bytes queued -> txd=1 immediately, STATUS=0x04 after release, no further frames.
REQ-035 Without DBUS_UART_TX_FIFO_EN: write 0x11 then 0x22 on consecutive cycles -> 0x11 popped into the shifter, 0x22 held (full=1, count=1); third write while held -> dropped, overflow=1; both frames sent back-to-back.
